// File: rtl/xcvr_rmw_master.sv
// rtl/xcvr_rmw_master.sv - Avalon-MM read/write/RMW command sequencer with per-phase timeout
module xcvr_rmw_master #(
  parameter int ADDR_WIDTH     = 15,
  parameter int DATA_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 1023,
  parameter int TO_WIDTH       = 10
) (
  input  logic                    clk,
  input  logic                    reset_n,
  input  logic                    cmd_valid,
  output logic                    cmd_ready,
  input  logic [1:0]              cmd_op,
  input  logic [ADDR_WIDTH-1:0]   cmd_addr,
  input  logic [DATA_WIDTH-1:0]   cmd_data,
  input  logic [DATA_WIDTH-1:0]   cmd_mask,
  output logic                    rsp_valid,
  output logic [DATA_WIDTH-1:0]   rsp_data,
  output logic                    rsp_error,
  output logic                    stray_rdv,
  output logic [ADDR_WIDTH-1:0]   m_address,
  output logic                    m_read,
  output logic                    m_write,
  output logic [DATA_WIDTH-1:0]   m_writedata,
  output logic [DATA_WIDTH/8-1:0] m_byteenable,
  output logic                    m_burstcount,
  output logic                    m_debugaccess,
  input  logic                    m_waitrequest,
  input  logic [DATA_WIDTH-1:0]   m_readdata,
  input  logic                    m_readdatavalid
);
  localparam logic [TO_WIDTH-1:0] TO_LAST = TO_WIDTH'(TIMEOUT_CYCLES - 1);

  typedef enum logic [2:0] {IDLE, RD_REQ, RD_WAIT, WR_REQ, DONE} state_t;

  state_t                  state_q, state_d;
  logic [1:0]              op_q, op_d;
  logic [DATA_WIDTH-1:0]   data_q, data_d;
  logic [DATA_WIDTH-1:0]   mask_q, mask_d;
  logic [DATA_WIDTH-1:0]   rd_q, rd_d;
  logic [DATA_WIDTH-1:0]   result_q, result_d;
  logic                    err_q, err_d;
  logic                    merge_q, merge_d;
  logic [TO_WIDTH-1:0]     cnt_q, cnt_d;
  logic                    cmd_ready_q, cmd_ready_d;
  logic                    rsp_valid_q, rsp_valid_d;
  logic [DATA_WIDTH-1:0]   rsp_data_q, rsp_data_d;
  logic                    rsp_error_q, rsp_error_d;
  logic                    stray_rdv_q, stray_rdv_d;
  logic [ADDR_WIDTH-1:0]   m_address_q, m_address_d;
  logic                    m_read_q, m_read_d;
  logic                    m_write_q, m_write_d;
  logic [DATA_WIDTH-1:0]   m_writedata_q, m_writedata_d;
  logic                    timed_out;
  logic [DATA_WIDTH-1:0]   merged;

  always_comb begin
    state_d       = state_q;
    op_d          = op_q;
    data_d        = data_q;
    mask_d        = mask_q;
    rd_d          = rd_q;
    result_d      = result_q;
    err_d         = err_q;
    merge_d       = 1'b0;
    cnt_d         = cnt_q + 1'b1;
    cmd_ready_d   = 1'b0;
    m_address_d   = m_address_q;
    m_read_d      = 1'b0;
    m_write_d     = 1'b0;
    m_writedata_d = m_writedata_q;
    timed_out     = (cnt_q == TO_LAST);
    merged        = (rd_q & ~mask_q) | (data_q & mask_q);
    // Response fields are presented one cycle after DONE so they line up with rsp_valid.
    rsp_valid_d   = (state_q == DONE);
    rsp_data_d    = (state_q == DONE) ? result_q : '0;
    rsp_error_d   = (state_q == DONE) && err_q;
    stray_rdv_d   = stray_rdv_q | (m_readdatavalid && (state_q != RD_WAIT));

    unique case (state_q)
      IDLE: begin
        cmd_ready_d = 1'b1;
        if (cmd_ready_q && cmd_valid) begin
          cmd_ready_d = 1'b0;
          op_d        = cmd_op;
          data_d      = cmd_data;
          mask_d      = cmd_mask;
          m_address_d = cmd_addr;
          result_d    = '0;
          err_d       = 1'b0;
          cnt_d       = '0;
          case (cmd_op)
            2'b00, 2'b10: begin
              state_d  = RD_REQ;
              m_read_d = 1'b1;
            end
            2'b01: begin
              state_d       = WR_REQ;
              m_write_d     = 1'b1;
              m_writedata_d = cmd_data;
            end
            default: begin
              state_d = DONE;
              err_d   = 1'b1;
            end
          endcase
        end
      end
      RD_REQ: begin
        if (!m_waitrequest) begin
          state_d = RD_WAIT;
          cnt_d   = '0;
        end else if (timed_out) begin
          state_d = DONE;
          err_d   = 1'b1;
        end else begin
          m_read_d = 1'b1;
        end
      end
      RD_WAIT: begin
        // An RMW spends one extra cycle here forming the merged word before the write phase.
        if (merge_q) begin
          result_d      = merged;
          m_writedata_d = merged;
          m_write_d     = 1'b1;
          state_d       = WR_REQ;
          cnt_d         = '0;
        end else if (m_readdatavalid) begin
          if (op_q == 2'b10) begin
            rd_d    = m_readdata;
            merge_d = 1'b1;
          end else begin
            result_d = m_readdata;
            state_d  = DONE;
          end
        end else if (timed_out) begin
          state_d = DONE;
          err_d   = 1'b1;
        end
      end
      WR_REQ: begin
        if (!m_waitrequest) begin
          state_d = DONE;
        end else if (timed_out) begin
          state_d  = DONE;
          err_d    = 1'b1;
          result_d = '0;
        end else begin
          m_write_d = 1'b1;
        end
      end
      DONE: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q       <= IDLE;
      op_q          <= 2'b00;
      data_q        <= '0;
      mask_q        <= '0;
      rd_q          <= '0;
      result_q      <= '0;
      err_q         <= 1'b0;
      merge_q       <= 1'b0;
      cnt_q         <= '0;
      cmd_ready_q   <= 1'b1;
      rsp_valid_q   <= 1'b0;
      rsp_data_q    <= '0;
      rsp_error_q   <= 1'b0;
      stray_rdv_q   <= 1'b0;
      m_address_q   <= '0;
      m_read_q      <= 1'b0;
      m_write_q     <= 1'b0;
      m_writedata_q <= '0;
    end else begin
      state_q       <= state_d;
      op_q          <= op_d;
      data_q        <= data_d;
      mask_q        <= mask_d;
      rd_q          <= rd_d;
      result_q      <= result_d;
      err_q         <= err_d;
      merge_q       <= merge_d;
      cnt_q         <= cnt_d;
      cmd_ready_q   <= cmd_ready_d;
      rsp_valid_q   <= rsp_valid_d;
      rsp_data_q    <= rsp_data_d;
      rsp_error_q   <= rsp_error_d;
      stray_rdv_q   <= stray_rdv_d;
      m_address_q   <= m_address_d;
      m_read_q      <= m_read_d;
      m_write_q     <= m_write_d;
      m_writedata_q <= m_writedata_d;
    end
  end

  assign cmd_ready     = cmd_ready_q;
  assign rsp_valid     = rsp_valid_q;
  assign rsp_data      = rsp_data_q;
  assign rsp_error     = rsp_error_q;
  assign stray_rdv     = stray_rdv_q;
  assign m_address     = m_address_q;
  assign m_read        = m_read_q;
  assign m_write       = m_write_q;
  assign m_writedata   = m_writedata_q;
  assign m_byteenable  = '1;
  assign m_burstcount  = 1'b1;
  assign m_debugaccess = 1'b0;
endmodule

// File: tb/tb_xcvr_rmw_master.sv
// tb/tb_xcvr_rmw_master.sv - self-checking bench for xcvr_rmw_master
module tb_xcvr_rmw_master;
  localparam int AW = 15;
  localparam int DW = 32;
  localparam int T  = 8;

  logic          clk = 1'b0;
  logic          reset_n;
  logic          cmd_valid, cmd_ready;
  logic [1:0]    cmd_op;
  logic [AW-1:0] cmd_addr;
  logic [DW-1:0] cmd_data, cmd_mask;
  logic          rsp_valid, rsp_error, stray_rdv;
  logic [DW-1:0] rsp_data;
  logic [AW-1:0] m_address;
  logic          m_read, m_write;
  logic [DW-1:0] m_writedata;
  logic [DW/8-1:0] m_byteenable;
  logic          m_burstcount, m_debugaccess;
  logic          m_waitrequest, m_readdatavalid;
  logic [DW-1:0] m_readdata;

  int   n_vec = 0;
  int   n_mis = 0;
  logic stray_exp = 1'b0;

  always #5 clk = ~clk;

  xcvr_rmw_master #(
    .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .TIMEOUT_CYCLES(T), .TO_WIDTH(4)
  ) dut (
    .clk(clk), .reset_n(reset_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_op(cmd_op),
    .cmd_addr(cmd_addr), .cmd_data(cmd_data), .cmd_mask(cmd_mask),
    .rsp_valid(rsp_valid), .rsp_data(rsp_data), .rsp_error(rsp_error),
    .stray_rdv(stray_rdv),
    .m_address(m_address), .m_read(m_read), .m_write(m_write),
    .m_writedata(m_writedata), .m_byteenable(m_byteenable),
    .m_burstcount(m_burstcount), .m_debugaccess(m_debugaccess),
    .m_waitrequest(m_waitrequest), .m_readdata(m_readdata),
    .m_readdatavalid(m_readdatavalid)
  );

  typedef struct {
    logic [1:0]    op;
    logic [AW-1:0] addr;
    logic [DW-1:0] data;
    logic [DW-1:0] mask;
    logic [DW-1:0] rdval;
    int            rw;
    int            rd;
    int            ww;
    logic [DW-1:0] exp_data;
    logic          exp_err;
    int            exp_rsp;
  } vec_t;

  vec_t tbl[12];

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_mis++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // rw: waitrequest cycles on the read, rd: readdatavalid delay after read acceptance,
  // ww: waitrequest cycles on the write. Values >= T (or rd > T) force a timeout.
  task automatic run_cmd(input logic [1:0] op, input logic [AW-1:0] addr,
                         input logic [DW-1:0] data, input logic [DW-1:0] mask,
                         input logic [DW-1:0] rdval, input int rw, input int rd,
                         input int ww, input string tag,
                         output int rsp_o, output logic [DW-1:0] data_o, output logic err_o);
    int            a, w0, rsp_exp, mr_exp, mw_exp, wrs_exp;
    logic [DW-1:0] dexp, wexp;
    logic          eexp;
    int            g, rq, wq, rdv_at, mr, mw, wrs, nrsp, early, unstable, rsp_act;
    logic          ready_act;
    logic [DW-1:0] d_act;
    logic          e_act;

    eexp = 1'b0; dexp = '0; mr_exp = 0; mw_exp = 0; wrs_exp = 0; w0 = -1; rsp_exp = 0;
    wexp = (rdval & ~mask) | (data & mask);
    if (op == 2'b11) begin
      eexp = 1'b1; rsp_exp = 2;
    end else if (op == 2'b01) begin
      w0 = 1; wexp = data;
    end else if (rw >= T) begin
      mr_exp = T; eexp = 1'b1; rsp_exp = T + 2;
    end else begin
      mr_exp = rw + 1;
      a = 1 + rw;
      if (rd > T) begin
        eexp = 1'b1; rsp_exp = a + T + 2;
      end else if (op == 2'b00) begin
        dexp = rdval; rsp_exp = a + rd + 2;
      end else begin
        w0 = a + rd + 2;
      end
    end
    if (w0 > 0) begin
      if (ww >= T) begin
        mw_exp = T; eexp = 1'b1; dexp = '0; rsp_exp = w0 + T + 1;
      end else begin
        mw_exp = ww + 1; wrs_exp = 1; rsp_exp = w0 + ww + 2;
        if (op == 2'b10) dexp = wexp;
      end
    end

    g = 0;
    while (!cmd_ready && g < 40) begin
      @(posedge clk); #1; g++;
    end
    chk({tag, ".ready_before"}, cmd_ready, 1);
    cmd_valid = 1'b1; cmd_op = op; cmd_addr = addr; cmd_data = data; cmd_mask = mask;
    @(posedge clk); #1;
    cmd_valid = 1'b0; cmd_op = 2'($urandom); cmd_addr = AW'($urandom);
    cmd_data = $urandom; cmd_mask = $urandom;

    rq = 0; wq = 0; rdv_at = -1; mr = 0; mw = 0; wrs = 0; nrsp = 0; early = 0;
    unstable = 0; rsp_act = -1; ready_act = 1'b0; d_act = '0; e_act = 1'b0;
    for (int cyc = 1; cyc < 80; cyc++) begin
      if (rsp_act >= 0 && cyc == rsp_act + 1) begin
        ready_act = cmd_ready;
        break;
      end
      if (rsp_valid) begin
        nrsp++;
        if (rsp_act < 0) begin
          rsp_act = cyc; d_act = rsp_data; e_act = rsp_error;
        end
      end
      if (cmd_ready) early++;
      if (m_read) begin
        mr++;
        if (m_address !== addr) unstable++;
      end
      if (m_write) begin
        mw++;
        if (m_address !== addr || m_writedata !== wexp) unstable++;
      end
      m_waitrequest = 1'b0;
      if (m_read) begin
        m_waitrequest = (rq < rw);
        if (rq == rw) rdv_at = cyc + rd;
        rq++;
      end else if (m_write) begin
        m_waitrequest = (wq < ww);
        if (wq == ww) wrs++;
        wq++;
      end
      m_readdatavalid = (cyc == rdv_at);
      m_readdata = (cyc == rdv_at) ? rdval : $urandom;
      @(posedge clk); #1;
    end
    m_waitrequest = 1'b0;
    m_readdatavalid = 1'b0;

    chk({tag, ".rsp_seen"}, rsp_act >= 0, 1);
    chk({tag, ".rsp_cycle"}, rsp_act, rsp_exp);
    chk({tag, ".rsp_data"}, d_act, dexp);
    chk({tag, ".rsp_error"}, e_act, eexp);
    chk({tag, ".rsp_count"}, nrsp, 1);
    chk({tag, ".ready_after"}, ready_act, 1);
    chk({tag, ".ready_busy"}, early, 0);
    chk({tag, ".m_read_cycles"}, mr, mr_exp);
    chk({tag, ".m_write_cycles"}, mw, mw_exp);
    chk({tag, ".writes_done"}, wrs, wrs_exp);
    chk({tag, ".bus_stable"}, unstable, 0);
    chk({tag, ".stray_rdv"}, stray_rdv, stray_exp);
    rsp_o = rsp_act; data_o = d_act; err_o = e_act;
  endtask

  initial begin
    int            r_cyc;
    logic [DW-1:0] r_data;
    logic          r_err;
    int            nrsp;
    int            sel, rw, rd, ww;
    logic [1:0]    op;

    tbl[0]  = '{2'b00, 15'h0012, 32'h0, 32'h0, 32'hDEADBEEF, 0, 1, 0, 32'hDEADBEEF, 1'b0, 4};
    tbl[1]  = '{2'b10, 15'h0100, 32'h00005A00, 32'h0000FF00, 32'h12345678, 0, 1, 0, 32'h12345A78, 1'b0, 6};
    tbl[2]  = '{2'b01, 15'h0040, 32'hCAFE0001, 32'h0, 32'h0, 0, 1, 3, 32'h0, 1'b0, 6};
    tbl[3]  = '{2'b01, 15'h0041, 32'hCAFE0002, 32'h0, 32'h0, 0, 1, 0, 32'h0, 1'b0, 3};
    tbl[4]  = '{2'b11, 15'h0042, 32'h11111111, 32'hFFFFFFFF, 32'h0, 0, 1, 0, 32'h0, 1'b1, 2};
    tbl[5]  = '{2'b00, 15'h0050, 32'h0, 32'h0, 32'hA5A50F0F, 2, 3, 0, 32'hA5A50F0F, 1'b0, 8};
    tbl[6]  = '{2'b10, 15'h0060, 32'h12345678, 32'h0F0F0F0F, 32'hFFFF0000, 1, 2, 2, 32'hF2F40608, 1'b0, 10};
    tbl[7]  = '{2'b01, 15'h0070, 32'h0BADF00D, 32'h0, 32'h0, 0, 1, 7, 32'h0, 1'b0, 10};
    tbl[8]  = '{2'b01, 15'h0071, 32'h0BADF00E, 32'h0, 32'h0, 0, 1, 8, 32'h0, 1'b1, 10};
    tbl[9]  = '{2'b00, 15'h0080, 32'h0, 32'h0, 32'h13579BDF, 7, 8, 0, 32'h13579BDF, 1'b0, 18};
    tbl[10] = '{2'b00, 15'h0090, 32'h0, 32'h0, 32'h24680ACE, 0, 40, 0, 32'h0, 1'b1, 11};
    tbl[11] = '{2'b10, 15'h00A0, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'h0, 8, 1, 0, 32'h0, 1'b1, 10};

    reset_n = 1'b1; cmd_valid = 1'b0; cmd_op = 2'b00; cmd_addr = '0; cmd_data = '0; cmd_mask = '0;
    m_waitrequest = 1'b0; m_readdatavalid = 1'b0; m_readdata = '0;
    #1 reset_n = 1'b0;
    #2;
    chk("reset.cmd_ready", cmd_ready, 1);
    chk("reset.rsp_valid", rsp_valid, 0);
    chk("reset.rsp_data", rsp_data, 0);
    chk("reset.rsp_error", rsp_error, 0);
    chk("reset.stray_rdv", stray_rdv, 0);
    chk("reset.m_read", m_read, 0);
    chk("reset.m_write", m_write, 0);
    chk("reset.m_address", m_address, 0);
    chk("reset.m_writedata", m_writedata, 0);
    chk("reset.m_byteenable", m_byteenable, 4'hF);
    chk("reset.m_burstcount", m_burstcount, 1);
    chk("reset.m_debugaccess", m_debugaccess, 0);
    repeat (2) @(posedge clk);
    #1 reset_n = 1'b1;
    @(posedge clk); #1;

    for (int i = 0; i < 12; i++) begin
      run_cmd(tbl[i].op, tbl[i].addr, tbl[i].data, tbl[i].mask, tbl[i].rdval,
              tbl[i].rw, tbl[i].rd, tbl[i].ww, $sformatf("tbl%0d", i), r_cyc, r_data, r_err);
      chk($sformatf("tbl%0d.exp_cycle", i), r_cyc, tbl[i].exp_rsp);
      chk($sformatf("tbl%0d.exp_data", i), r_data, tbl[i].exp_data);
      chk($sformatf("tbl%0d.exp_err", i), r_err, tbl[i].exp_err);
    end

    for (int i = 0; i < 40; i++) begin
      sel = $urandom_range(0, 9);
      op  = (sel < 3) ? 2'b00 : (sel < 6) ? 2'b01 : (sel < 9) ? 2'b10 : 2'b11;
      rw  = ($urandom_range(0, 7) == 0) ? T : $urandom_range(0, 3);
      rd  = ($urandom_range(0, 7) == 0) ? 20 : $urandom_range(1, 4);
      ww  = ($urandom_range(0, 7) == 0) ? T + 1 : $urandom_range(0, 3);
      run_cmd(op, AW'($urandom), $urandom, $urandom, $urandom, rw, rd, ww,
              $sformatf("rnd%0d", i), r_cyc, r_data, r_err);
    end

    // RMW whose read data never arrives, then a late readdatavalid
    run_cmd(2'b10, 15'h0200, 32'h0000FFFF, 32'h0000FFFF, 32'h87654321, 0, 40, 0,
            "rmw_to", r_cyc, r_data, r_err);
    m_readdatavalid = 1'b1; m_readdata = 32'h87654321;
    @(posedge clk); #1;
    m_readdatavalid = 1'b0;
    stray_exp = 1'b1;
    chk("late_rdv.stray_rdv", stray_rdv, 1);
    run_cmd(2'b00, 15'h0201, 32'h0, 32'h0, 32'h00C0FFEE, 1, 2, 0,
            "after_stray", r_cyc, r_data, r_err);

    // reset pulsed while the write phase is stalled
    cmd_valid = 1'b1; cmd_op = 2'b01; cmd_addr = 15'h0033; cmd_data = 32'h55AA55AA; cmd_mask = '0;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    m_waitrequest = 1'b1;
    @(posedge clk); #1;
    chk("rst_mid.m_write_before", m_write, 1);
    chk("rst_mid.m_writedata", m_writedata, 32'h55AA55AA);
    #2 reset_n = 1'b0;
    #1;
    chk("rst_mid.m_write_async", m_write, 0);
    chk("rst_mid.cmd_ready_async", cmd_ready, 1);
    nrsp = 0;
    for (int c = 0; c < 3; c++) begin
      @(posedge clk); #1;
      if (rsp_valid) nrsp++;
    end
    reset_n = 1'b1;
    m_waitrequest = 1'b0;
    stray_exp = 1'b0;
    for (int c = 0; c < 4; c++) begin
      @(posedge clk); #1;
      if (rsp_valid) nrsp++;
    end
    chk("rst_mid.no_rsp", nrsp, 0);
    chk("rst_mid.cmd_ready", cmd_ready, 1);
    chk("rst_mid.stray_cleared", stray_rdv, 0);
    chk("rst_mid.m_write_idle", m_write, 0);
    run_cmd(2'b00, 15'h0012, 32'h0, 32'h0, 32'h5EED5EED, 0, 1, 0,
            "post_rst", r_cyc, r_data, r_err);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_mis);
    $finish;
  end
endmodule
